pixel_stream_source: RTL and testbench
======================================

// Module: pixel_stream_source
// PURPOSE
// - Raster pixel transmitter that drives the 12-bit RGB444 pixel input of the blurring/VFX filter chain.
// - Emits whole frames of IMG_W x IMG_H pixels in row-major order over a valid/ready stream with sop/eop framing.
// - Used as the on-chip stimulus source for filter bring-up and for self-checking benches; replaces hand-fed pixels.
// PARAMETERS
// - IMG_W        15  pixels per line (>=2)
// - IMG_H        15  lines per frame (>=2)
// - BLANK_CYCLES 4   idle cycles between frames in continuous mode (>=1)
// PORTS
// - clk          in   1   system clock; all logic rising-edge
// - reset        in   1   synchronous, active-high reset
// - start        in   1   one-cycle request to begin a frame; sampled only in IDLE
// - continuous   in   1   1: repeat frames until cleared; sampled at each frame end
// - pattern      in   2   00 gradient, 01 solid white, 10 checkerboard, 11 column ramp
// - out_ready    in   1   downstream accepts the beat when out_valid & out_ready
// - out_valid    out  1   beat valid
// - out_data     out  12  pixel, {R[3:0],G[3:0],B[3:0]}
// - out_sop      out  1   high with the first pixel (row 0, col 0)
// - out_eop      out  1   high with the last pixel (row IMG_H-1, col IMG_W-1)
// - busy         out  1   high in STREAM and BLANK
// - frame_done   out  1   one-cycle pulse the cycle after the eop beat is accepted
// - frame_count  out  16  number of completed frames, wraps 0xFFFF->0
// BEHAVIOUR
// - Reset: state IDLE; out_valid, out_sop, out_eop, busy, frame_done = 0; out_data = 0; frame_count = 0; counters 0.
// - Reset mid-frame aborts immediately; the next cycle shows out_valid = 0 and no eop is ever emitted for the aborted frame.
// - FSM IDLE -> STREAM on start; STREAM -> BLANK, or STREAM -> IDLE, on the accepted eop beat; BLANK -> STREAM after BLANK_CYCLES cycles.
// - Exit from STREAM goes to BLANK when continuous = 1 at that cycle, otherwise to IDLE.
// - In BLANK, if continuous is 0 when the blank count expires, go to IDLE instead of STREAM.
// - pattern is latched on IDLE->STREAM and BLANK->STREAM; changes mid-frame have no effect until the next frame.
// - Latency: start at cycle N -> out_valid = 1 with the sop pixel at cycle N+1.
// - Handshake: out_valid stays high for the whole STREAM state, with no gaps that the source inserts.
// - While out_ready = 0, out_data, out_sop and out_eop hold stable; the position advances only on an accepted beat.
// - Position counters: col 0..IMG_W-1, row 0..IMG_H-1, plus a linear index idx = row*IMG_W + col.
//   - idx is kept as a separate incrementing counter; no multiplier.
//   - col wraps to 0 and row increments when col = IMG_W-1 is accepted.
// - Pixel values:
//   - gradient: idx[11:0], truncated modulo 4096.
//   - solid: 12'hFFF.
//   - checkerboard: (row[0]^col[0]) ? 12'hFFF : 12'h000.
//   - column ramp: {col[3:0],col[3:0],col[3:0]}.
// - out_data is registered, i.e. the value for the current position is presented in the same cycle as out_valid.
// - frame_done pulses exactly once per completed frame; frame_count increments in the same cycle as the pulse.
// - start during STREAM or BLANK is ignored, and is not queued.
// - start and reset in the same cycle: reset wins.
// - Outputs in BLANK and IDLE: out_valid = 0, out_sop = 0, out_eop = 0.
// TESTING
// - Reset, then start with pattern=00, out_ready=1 held:
//   - 225 beats follow.
//   - beat0 = 0x000 with sop; beat 224 = 0x0E0 with eop.
//   - frame_done pulses one cycle later; frame_count = 1.
// - Backpressure:
//   - Toggle out_ready pseudo-randomly; the accepted sequence must still be 0x000..0x0E0 in order.
//   - out_data must stay stable on every cycle where valid & !ready.
// - continuous=1, pattern=01:
//   - Run 3 frames, each all 0xFFF.
//   - Exactly 4 idle cycles between an eop accept and the next sop.
//   - frame_count ends at 3.
// - pattern=10, then change pattern to 11 at beat 50:
//   - Frame stays checkerboard: (0,0)=0x000, (0,1)=0xFFF, (1,0)=0xFFF.
//   - The next frame is the ramp: (3,7)=0x777.
// - Assert reset at beat 100 of a frame:
//   - out_valid = 0 on the next cycle; no eop; frame_count = 0.
//   - A new start yields a sop pixel of 0x000.
// - start pulsed during STREAM and BLANK:
//   - No effect.
//   - With continuous=0 the block returns to IDLE after one frame and busy = 0.

Source files
------------

// File: rtl/pixel_stream_source.sv
// pixel_stream_source
// Raster pixel transmitter feeding the 12-bit RGB444 input of the filter chain.
// Emits IMG_W x IMG_H frames in row-major order over valid/ready with sop/eop.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               one-cycle frame request, honoured only in IDLE
//   continuous          repeat frames while high, sampled at each frame end
//   pattern             00 gradient, 01 solid white, 10 checkerboard, 11 column ramp
//   out_ready           downstream accept
//   out_valid/out_data  registered beat and pixel {R,G,B}
//   out_sop/out_eop     first / last pixel of the frame
//   busy                high in STREAM and BLANK
//   frame_done          one-cycle pulse after the eop beat is accepted
//   frame_count         completed frames, wrapping
module pixel_stream_source #(
   parameter int unsigned IMG_W        = 15,
   parameter int unsigned IMG_H        = 15,
   parameter int unsigned BLANK_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        continuous,
   input  logic [1:0]  pattern,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [11:0] out_data,
   output logic        out_sop,
   output logic        out_eop,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] frame_count
);

   localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int unsigned IW = $clog2(IMG_W * IMG_H);
   localparam int unsigned BW = $clog2(BLANK_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      STREAM = 2'b01,
      BLANK  = 2'b10
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] col, col_nxt;
   logic [RW-1:0] row, row_nxt;
   logic [IW-1:0] idx, idx_nxt;
   logic [BW-1:0] blank_cnt, blank_nxt;
   logic [1:0]    pat, pat_nxt;
   logic          accept, last_col, last_pix, frame_end;
   logic          stream_nxt, sop_nxt, eop_nxt;
   logic [11:0]   pix_nxt;

   // Next state, next position and the pixel for the next presented beat
   always_comb begin
      state_nxt = state;
      col_nxt   = col;
      row_nxt   = row;
      idx_nxt   = idx;
      blank_nxt = blank_cnt;
      pat_nxt   = pat;
      accept    = (state == STREAM) && out_ready;
      last_col  = (col == CW'(IMG_W - 1));
      last_pix  = last_col && (row == RW'(IMG_H - 1));
      frame_end = accept && last_pix;

      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = STREAM;
               pat_nxt   = pattern;
               col_nxt   = '0;
               row_nxt   = '0;
               idx_nxt   = '0;
            end
         end
         STREAM: begin
            if (accept) begin
               if (last_pix) begin
                  state_nxt = continuous ? BLANK : IDLE;
                  col_nxt   = '0;
                  row_nxt   = '0;
                  idx_nxt   = '0;
                  blank_nxt = '0;
               end else if (last_col) begin
                  col_nxt = '0;
                  row_nxt = row + RW'(1);
                  idx_nxt = idx + IW'(1);
               end else begin
                  col_nxt = col + CW'(1);
                  idx_nxt = idx + IW'(1);
               end
            end
         end
         BLANK: begin
            if (blank_cnt == BW'(BLANK_CYCLES - 1)) begin
               blank_nxt = '0;
               if (continuous) begin
                  state_nxt = STREAM;
                  pat_nxt   = pattern;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               blank_nxt = blank_cnt + BW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase

      stream_nxt = (state_nxt == STREAM);
      sop_nxt    = stream_nxt && (col_nxt == '0) && (row_nxt == '0);
      eop_nxt    = stream_nxt && (col_nxt == CW'(IMG_W - 1)) && (row_nxt == RW'(IMG_H - 1));

      case (pat_nxt)
         2'b00:   pix_nxt = 12'(idx_nxt);
         2'b01:   pix_nxt = 12'hFFF;
         2'b10:   pix_nxt = (row_nxt[0] ^ col_nxt[0]) ? 12'hFFF : 12'h000;
         default: pix_nxt = {3{4'(col_nxt)}};
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         col         <= '0;
         row         <= '0;
         idx         <= '0;
         blank_cnt   <= '0;
         pat         <= 2'b00;
         out_valid   <= 1'b0;
         out_data    <= 12'h000;
         out_sop     <= 1'b0;
         out_eop     <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         frame_count <= 16'h0000;
      end else begin
         state       <= state_nxt;
         col         <= col_nxt;
         row         <= row_nxt;
         idx         <= idx_nxt;
         blank_cnt   <= blank_nxt;
         pat         <= pat_nxt;
         out_valid   <= stream_nxt;
         out_data    <= stream_nxt ? pix_nxt : 12'h000;
         out_sop     <= sop_nxt;
         out_eop     <= eop_nxt;
         busy        <= (state_nxt != IDLE);
         frame_done  <= frame_end;
         frame_count <= frame_count + 16'(frame_end);
      end
   end

endmodule

// File: tb/tb_pixel_stream_source.sv
// Directed bench for pixel_stream_source (15x15 frames, 4 blank cycles).
module tb_pixel_stream_source;

   logic        clk = 1'b0;
   logic        reset, start, continuous, out_ready;
   logic [1:0]  pattern;
   logic        out_valid, out_sop, out_eop, busy, frame_done;
   logic [11:0] out_data;
   logic [15:0] frame_count;

   int checks = 0;
   int errors = 0;

   logic [11:0] beats [0:224];
   int          nbeats, lead, extra_sop;
   bit          got_eop, first_sop;

   pixel_stream_source #(.IMG_W(15), .IMG_H(15), .BLANK_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .start(start), .continuous(continuous),
      .pattern(pattern), .out_ready(out_ready), .out_valid(out_valid),
      .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop), .busy(busy),
      .frame_done(frame_done), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; continuous = 1'b0; out_ready = 1'b1; pattern = 2'b00;
      step(); step();
      reset = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1; step(); start = 1'b0;
   endtask

   // Records accepted beats of one frame with out_ready held high (no checks here)
   task automatic capture_frame(input int change_at, input logic [1:0] new_pat,
                                input bit clr_cont, input int start_at);
      int guard = 0;
      nbeats = 0; lead = 0; extra_sop = 0; got_eop = 0; first_sop = 0;
      while (!got_eop && guard < 2000) begin
         start = 1'b0;
         if (out_valid && out_ready) begin
            if (nbeats == 0) begin
               first_sop = out_sop;
               if (clr_cont) continuous = 1'b0;
            end else if (out_sop) extra_sop++;
            if (nbeats < 225) beats[nbeats] = out_data;
            if (nbeats == change_at) pattern = new_pat;
            if (nbeats == start_at) start = 1'b1;
            if (out_eop) got_eop = 1;
            nbeats++;
         end else if (nbeats == 0) lead++;
         step();
         guard++;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({out_valid, out_sop, out_eop, busy, frame_done} !== 5'b0 || out_data !== 12'h000 ||
          frame_count !== 16'h0) begin
         errors++;
         $display("FAIL reset_state: valid=%b sop=%b eop=%b busy=%b done=%b data=%h cnt=%0d, required all 0",
                  out_valid, out_sop, out_eop, busy, frame_done, out_data, frame_count);
      end
   endtask

   task automatic test_gradient();
      int bad = 0;
      do_reset();
      pulse_start();
      checks++;
      if (out_valid !== 1'b1 || out_sop !== 1'b1 || out_data !== 12'h000 || busy !== 1'b1) begin
         errors++;
         $display("FAIL grad_latency: valid=%b sop=%b data=%h busy=%b, required 1 1 000 1",
                  out_valid, out_sop, out_data, busy);
      end
      capture_frame(-1, 2'b00, 0, -1);
      checks++;
      if (nbeats != 225 || !got_eop || !first_sop || extra_sop != 0) begin
         errors++;
         $display("FAIL grad_framing: beats=%0d eop=%b sop0=%b extra_sop=%0d, required 225 1 1 0",
                  nbeats, got_eop, first_sop, extra_sop);
      end
      checks++;
      if (beats[224] !== 12'h0E0) begin
         errors++;
         $display("FAIL grad_last: got %h, required 0e0", beats[224]);
      end
      for (int i = 0; i < 225; i++) if (beats[i] !== 12'(i)) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL grad_values: %0d wrong beats, required 0", bad);
      end
      checks++;
      if (frame_done !== 1'b1 || frame_count !== 16'd1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL grad_done: done=%b cnt=%0d busy=%b valid=%b, required 1 1 0 0",
                  frame_done, frame_count, busy, out_valid);
      end
      step();
      checks++;
      if (frame_done !== 1'b0 || frame_count !== 16'd1) begin
         errors++;
         $display("FAIL grad_pulse_width: done=%b cnt=%0d, required 0 1", frame_done, frame_count);
      end
   endtask

   task automatic test_backpressure();
      int k = 0, guard = 0, bad_val = 0, bad_hold = 0;
      bit done = 0, holding = 0;
      logic [11:0] hd;
      logic hs, he;
      do_reset();
      pulse_start();
      while (!done && guard < 4000) begin
         out_ready = 1'($urandom_range(0, 1));
         if (holding) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== hd || out_sop !== hs || out_eop !== he) begin
               errors++; bad_hold++;
               if (bad_hold < 4)
                  $display("FAIL bp_hold: valid=%b data=%h sop=%b eop=%b, required 1 %h %b %b",
                           out_valid, out_data, out_sop, out_eop, hd, hs, he);
            end
         end
         holding = 0;
         if (out_valid) begin
            if (out_ready) begin
               checks++;
               if (out_data !== 12'(k) || out_sop !== (k == 0) || out_eop !== (k == 224)) begin
                  errors++; bad_val++;
                  if (bad_val < 4)
                     $display("FAIL bp_beat%0d: data=%h sop=%b eop=%b, required %h %b %b",
                              k, out_data, out_sop, out_eop, 12'(k), k == 0, k == 224);
               end
               if (out_eop) done = 1;
               k++;
            end else begin
               holding = 1; hd = out_data; hs = out_sop; he = out_eop;
            end
         end
         step();
         guard++;
      end
      out_ready = 1'b1;
      checks++;
      if (!done || k != 225 || frame_count !== 16'd1) begin
         errors++;
         $display("FAIL bp_complete: eop=%b beats=%0d cnt=%0d, required 1 225 1", done, k, frame_count);
      end
   endtask

   task automatic test_continuous();
      int bad;
      do_reset();
      pattern = 2'b01; continuous = 1'b1;
      pulse_start();
      for (int f = 0; f < 3; f++) begin
         capture_frame(-1, 2'b01, f == 2, -1);
         bad = 0;
         for (int i = 0; i < 225; i++) if (beats[i] !== 12'hFFF) bad++;
         checks++;
         if (nbeats != 225 || bad != 0 || !first_sop) begin
            errors++;
            $display("FAIL cont_frame%0d: beats=%0d bad=%0d sop0=%b, required 225 0 1", f, nbeats, bad, first_sop);
         end
         if (f > 0) begin
            checks++;
            if (lead != 4) begin
               errors++;
               $display("FAIL cont_gap%0d: %0d idle cycles, required 4", f, lead);
            end
         end
      end
      step();
      checks++;
      if (frame_count !== 16'd3 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL cont_end: cnt=%0d busy=%b valid=%b, required 3 0 0", frame_count, busy, out_valid);
      end
   endtask

   task automatic test_pattern_change();
      do_reset();
      pattern = 2'b10; continuous = 1'b1;
      pulse_start();
      capture_frame(50, 2'b11, 0, -1);
      checks++;
      if (beats[0] !== 12'h000 || beats[1] !== 12'hFFF || beats[15] !== 12'hFFF ||
          beats[52] !== 12'h000 || beats[224] !== 12'h000) begin
         errors++;
         $display("FAIL chk_frame: (0,0)=%h (0,1)=%h (1,0)=%h (3,7)=%h (14,14)=%h, required 000 fff fff 000 000",
                  beats[0], beats[1], beats[15], beats[52], beats[224]);
      end
      capture_frame(-1, 2'b11, 1, -1);
      checks++;
      if (beats[52] !== 12'h777 || beats[0] !== 12'h000 || beats[224] !== 12'hEEE || lead != 4) begin
         errors++;
         $display("FAIL ramp_frame: (3,7)=%h (0,0)=%h (14,14)=%h gap=%0d, required 777 000 eee 4",
                  beats[52], beats[0], beats[224], lead);
      end
   endtask

   task automatic test_reset_mid();
      int k = 0, guard = 0, seen = 0;
      do_reset();
      pattern = 2'b00;
      pulse_start();
      while (k < 100 && guard < 500) begin
         if (out_valid && out_ready) k++;
         step(); guard++;
      end
      reset = 1'b1; start = 1'b1;
      step();
      reset = 1'b0; start = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || frame_count !== 16'd0 || k != 100) begin
         errors++;
         $display("FAIL mid_reset: valid=%b busy=%b cnt=%0d beats=%0d, required 0 0 0 100",
                  out_valid, busy, frame_count, k);
      end
      for (int i = 0; i < 300; i++) begin
         if (out_valid || out_eop || frame_done) seen++;
         step();
      end
      checks++;
      if (seen != 0 || frame_count !== 16'd0) begin
         errors++;
         $display("FAIL mid_reset_quiet: %0d active cycles cnt=%0d, required 0 0", seen, frame_count);
      end
      pulse_start();
      checks++;
      if (out_valid !== 1'b1 || out_sop !== 1'b1 || out_data !== 12'h000) begin
         errors++;
         $display("FAIL mid_reset_restart: valid=%b sop=%b data=%h, required 1 1 000", out_valid, out_sop, out_data);
      end
   endtask

   task automatic test_start_ignored();
      int bad = 0, seen = 0;
      do_reset();
      pattern = 2'b00; continuous = 1'b1;
      pulse_start();
      capture_frame(-1, 2'b00, 0, 10);
      for (int i = 0; i < 225; i++) if (beats[i] !== 12'(i)) bad++;
      checks++;
      if (nbeats != 225 || bad != 0 || extra_sop != 0) begin
         errors++;
         $display("FAIL start_in_stream: beats=%0d bad=%0d extra_sop=%0d, required 225 0 0", nbeats, bad, extra_sop);
      end
      pulse_start();
      capture_frame(-1, 2'b00, 1, 20);
      checks++;
      if (lead != 3 || nbeats != 225 || extra_sop != 0) begin
         errors++;
         $display("FAIL start_in_blank: gap=%0d beats=%0d extra_sop=%0d, required 3 225 0", lead, nbeats, extra_sop);
      end
      step();
      for (int i = 0; i < 20; i++) begin
         if (out_valid || busy) seen++;
         step();
      end
      checks++;
      if (seen != 0 || busy !== 1'b0 || frame_count !== 16'd2) begin
         errors++;
         $display("FAIL start_idle_return: active=%0d busy=%b cnt=%0d, required 0 0 2", seen, busy, frame_count);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; continuous = 1'b0; out_ready = 1'b1; pattern = 2'b00;
      test_reset();
      test_gradient();
      test_backpressure();
      test_continuous();
      test_pattern_change();
      test_reset_mid();
      test_start_ignored();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
